// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with load, clear, direction,
// illegal-state self-correction, one-hot phase decode and wrap/err pulses.
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 clr,
    input  logic                 load,
    input  logic [IW-1:0]        load_idx,
    output logic [WIDTH-1:0]     q,
    output logic [IW-1:0]        idx,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 wrap,
    output logic                 err
);

    localparam logic [IW:0]   LEN  = (IW + 1)'(2 * WIDTH);
    localparam logic [IW-1:0] LAST = IW'(2 * WIDTH - 1);

    // Low k bits set up to the half-way code, then ones drain from the bottom.
    function automatic logic [WIDTH-1:0] code_of(input logic [IW-1:0] k);
        int kv;
        kv = int'(k);
        code_of = '0;
        for (int i = 0; i < WIDTH; i++)
            code_of[i] = (kv <= WIDTH) ? (i < kv) : (i >= kv - WIDTH);
    endfunction

    logic idx_bad;
    logic illegal;
    logic load_ok;

    assign idx_bad = ({1'b0, idx} >= LEN);
    assign illegal = idx_bad || (q != code_of(idx));
    assign load_ok = ({1'b0, load_idx} < LEN);

    assign phase = {{(2 * WIDTH - 1){1'b0}}, 1'b1} << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            idx  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // A corrupted state is flagged even when clr or load wins.
            err  <= illegal;
            if (clr) begin
                q   <= '0;
                idx <= '0;
            end else if (load && load_ok) begin
                q   <= code_of(load_idx);
                idx <= load_idx;
            end else if (load) begin
                q   <= '0;
                idx <= '0;
                err <= 1'b1;
            end else if (illegal) begin
                q   <= '0;
                idx <= '0;
            end else if (en) begin
                if (!dir) begin
                    q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
                    if (idx == LAST) begin
                        idx  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end else begin
                    q <= {~q[0], q[WIDTH-1:1]};
                    if (idx == '0) begin
                        idx  <= LAST;
                        wrap <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param: vector table plus
// hand-written corner sequences, checked through an expectation queue.
module tb_johnson_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en4, dir4, clr4, load4;
    logic [2:0] lidx4;
    logic [3:0] q4;
    logic [2:0] idx4;
    logic [7:0] ph4;
    logic       wrap4, err4;

    logic       en3, dir3, clr3, load3;
    logic [2:0] lidx3;
    logic [2:0] q3;
    logic [2:0] idx3;
    logic [5:0] ph3;
    logic       wrap3, err3;

    logic       rst5;
    logic       en5, dir5, clr5, load5;
    logic [3:0] lidx5;
    logic [4:0] q5;
    logic [3:0] idx5;
    logic [9:0] ph5;
    logic       wrap5, err5;

    johnson_counter_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .dir(dir4), .clr(clr4),
        .load(load4), .load_idx(lidx4), .q(q4), .idx(idx4),
        .phase(ph4), .wrap(wrap4), .err(err4)
    );

    johnson_counter_param #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .dir(dir3), .clr(clr3),
        .load(load3), .load_idx(lidx3), .q(q3), .idx(idx3),
        .phase(ph3), .wrap(wrap3), .err(err3)
    );

    johnson_counter_param #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst5), .en(en5), .dir(dir5), .clr(clr5),
        .load(load5), .load_idx(lidx5), .q(q5), .idx(idx5),
        .phase(ph5), .wrap(wrap5), .err(err5)
    );

    typedef struct {
        int         unit;
        logic [15:0] q;
        logic [3:0]  idx;
        logic        wrap;
        logic        err;
    } exp_t;

    typedef struct {
        logic       en, dir, clr, load;
        logic [2:0] li;
        logic [3:0] q;
        logic [2:0] idx;
        logic       wrap, err;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_out(input int unit, input logic [15:0] eq,
                              input logic [3:0] ei, input logic ew,
                              input logic ee);
        sb.push_back('{unit, eq, ei, ew, ee});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        logic [15:0] aq, ap, ep;
        logic [3:0]  ai;
        logic        aw, ae;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        case (e.unit)
            0: begin
                aq = 16'(q4); ai = 4'(idx4); ap = 16'(ph4);
                aw = wrap4; ae = err4;
            end
            1: begin
                aq = 16'(q3); ai = 4'(idx3); ap = 16'(ph3);
                aw = wrap3; ae = err3;
            end
            default: begin
                aq = 16'(q5); ai = idx5; ap = 16'(ph5);
                aw = wrap5; ae = err5;
            end
        endcase
        ep = 16'(1) << e.idx;
        chk({tag, " q"}, 32'(aq), 32'(e.q));
        chk({tag, " idx"}, 32'(ai), 32'(e.idx));
        chk({tag, " phase"}, 32'(ap), 32'(ep));
        chk({tag, " wrap"}, 32'(aw), 32'(e.wrap));
        chk({tag, " err"}, 32'(ae), 32'(e.err));
    endtask

    task automatic add(input logic en, dir, clr, load, input logic [2:0] li,
                       input logic [3:0] q, input logic [2:0] idx,
                       input logic wrap, err);
        tbl.push_back('{en, dir, clr, load, li, q, idx, wrap, err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rst5 = 1'b1;
        {en4, dir4, clr4, load4} = '0; lidx4 = '0;
        {en3, dir3, clr3, load3} = '0; lidx3 = '0;
        {en5, dir5, clr5, load5} = '0; lidx5 = '0;

        // forward lap with wrap, then reversal through 0
        for (int i = 0; i < 11; i++) begin : fwd
            logic [3:0] c [0:7];
            c = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                  4'b1111, 4'b1110, 4'b1100, 4'b1000};
            add(1, 0, 0, 0, 0, c[(i + 1) % 8], 3'((i + 1) % 8),
                (i == 7), 0);
        end
        add(1, 1, 0, 0, 0, 4'b0011, 2, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0001, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b1000, 7, 1, 0);
        add(1, 1, 0, 0, 0, 4'b1100, 6, 0, 0);
        add(0, 0, 0, 1, 5, 4'b1110, 5, 0, 0);
        add(0, 0, 1, 1, 5, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 1, 2, 4'b0011, 2, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0011, 2, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0011, 2, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0011, 2, 0, 0);
        add(1, 0, 0, 1, 6, 4'b1100, 6, 0, 0);
        add(1, 0, 0, 0, 0, 4'b1000, 7, 0, 0);
        add(1, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 1, 4, 4'b1111, 4, 0, 0);
        add(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0001, 1, 0, 0);

        #3;
        chk("rst q", 32'(q4), 0);
        chk("rst idx", 32'(idx4), 0);
        chk("rst phase", 32'(ph4), 1);
        chk("rst wrap", 32'(wrap4), 0);
        chk("rst err", 32'(err4), 0);
        chk("rst q5", 32'(q5), 0);
        #4 rst = 1'b0; rst5 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            en4 = tbl[i].en; dir4 = tbl[i].dir;
            clr4 = tbl[i].clr; load4 = tbl[i].load; lidx4 = tbl[i].li;
            expect_out(0, 16'(tbl[i].q), 4'(tbl[i].idx),
                       tbl[i].wrap, tbl[i].err);
            @(posedge clk); #1;
            pop_check($sformatf("v%0d", i));
        end

        // corrupted state is corrected, then counting resumes
        @(negedge clk);
        {en4, dir4, clr4, load4} = 4'b1000;
        force dut4.q = 4'b0101;
        #1 release dut4.q;
        expect_out(0, 16'h0, 4'd0, 0, 1);
        @(posedge clk); #1;
        pop_check("seu");
        @(negedge clk);
        expect_out(0, 16'h1, 4'd1, 0, 0);
        @(posedge clk); #1;
        pop_check("seu+1");
        @(negedge clk);
        expect_out(0, 16'h3, 4'd2, 0, 0);
        @(posedge clk); #1;
        pop_check("seu+2");
        @(negedge clk);
        en4 = 1'b0;

        // WIDTH=3: out-of-range loads
        begin : w3
            logic [2:0] li  [0:5];
            logic [2:0] eq  [0:5];
            logic [2:0] ei  [0:5];
            logic       ld  [0:5];
            logic       ee  [0:5];
            li = '{3'd4, 3'd6, 3'd0, 3'd2, 3'd7, 3'd0};
            ld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            eq = '{3'b110, 3'b000, 3'b000, 3'b011, 3'b000, 3'b001};
            ei = '{3'd4, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1};
            ee = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                load3 = ld[i]; lidx3 = li[i]; en3 = (i == 5);
                expect_out(1, 16'(eq[i]), 4'(ei[i]), 0, ee[i]);
                @(posedge clk); #1;
                pop_check($sformatf("w3_%0d", i));
            end
            @(negedge clk);
            {en3, load3} = 2'b00;
        end

        // WIDTH=5: count to idx 7, then async reset between edges
        begin : w5
            logic [4:0] c [0:7];
            c = '{5'b00000, 5'b00001, 5'b00011, 5'b00111,
                  5'b01111, 5'b11111, 5'b11110, 5'b11100};
            for (int i = 1; i <= 7; i++) begin
                @(negedge clk);
                en5 = 1'b1;
                expect_out(2, 16'(c[i]), 4'(i), 0, 0);
                @(posedge clk); #1;
                pop_check($sformatf("w5_%0d", i));
            end
            @(negedge clk);
            en5 = 1'b0;
            #2 rst5 = 1'b1;
            #1;
            chk("async q5", 32'(q5), 0);
            chk("async idx5", 32'(idx5), 0);
            chk("async phase5", 32'(ph5), 1);
            chk("async wrap5", 32'(wrap5), 0);
        end

        chk("sb drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
